issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard_pkg.sv | 33 +++
 rtl/issue_scoreboard_if.sv | 28 ++
 rtl/issue_scoreboard_slot.sv | 25 ++
 rtl/issue_scoreboard.sv | 98 +++++++++
 tb/tb_issue_scoreboard.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared ARM issue constants: register mask width, CPSR bit position in a slot,
// default pipeline depth, and slot packing helpers.
package issue_scoreboard_pkg;

  localparam int REG_W         = 16;
  localparam int CPSR_BIT      = 0;
  localparam int SLOT_W        = REG_W + 1;
  localparam int DEPTH_DEFAULT = 3;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Slot layout: {def_regs, def_cpsr}, CPSR at bit CPSR_BIT
  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_CLEAR = 2'd1,
    SLOT_LOAD  = 2'd2
  } slot_ctrl_e;

  function automatic slot_t slot_pack(input logic [REG_W-1:0] regs, input logic cpsr);
    return {regs, cpsr};
  endfunction

  function automatic logic [REG_W-1:0] slot_regs(input slot_t s);
    return s[SLOT_W-1:CPSR_BIT+1];
  endfunction

  function automatic logic slot_cpsr(input slot_t s);
    return s[CPSR_BIT];
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue-stage scoreboard bus: issuing instruction's use/def masks, pipeline
// controls, and the scoreboard's hazard/busy/bubble/statistics outputs.
interface issue_scoreboard_if import issue_scoreboard_pkg::*; ();

  logic             stall;
  logic             flush;
  logic             inbubble;
  logic [REG_W-1:0] use_regs;
  logic             use_cpsr;
  logic [REG_W-1:0] def_regs;
  logic             def_cpsr;
  logic             hazard;
  logic             outbubble;
  logic [REG_W-1:0] busy_regs;
  logic             busy_cpsr;
  logic [15:0]      hazard_cycles;

  modport master (
    output stall, flush, inbubble, use_regs, use_cpsr, def_regs, def_cpsr,
    input  hazard, outbubble, busy_regs, busy_cpsr, hazard_cycles
  );

  modport slave (
    input  stall, flush, inbubble, use_regs, use_cpsr, def_regs, def_cpsr,
    output hazard, outbubble, busy_regs, busy_cpsr, hazard_cycles
  );

endinterface

// File: rtl/issue_scoreboard_slot.sv
// One scoreboard slot: holds an in-flight {def_regs, def_cpsr} with
// hold / clear / load control.
module scoreboard_slot import issue_scoreboard_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  slot_ctrl_e ctrl,
  input  slot_t      d,
  output slot_t      q
);

  // Slot register update
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {SLOT_W{1'b0}};
    end else begin
      case (ctrl)
        SLOT_HOLD:  q <= q;
        SLOT_CLEAR: q <= {SLOT_W{1'b0}};
        SLOT_LOAD:  q <= d;
        default:    q <= {SLOT_W{1'b0}};
      endcase
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks destination registers/flags of the DEPTH
// instructions between issue and writeback and holds dependent readers.
module issue_scoreboard import issue_scoreboard_pkg::*; #(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  issue_scoreboard_if.slave sb
);

  slot_t       slot_q_s [DEPTH];
  slot_t       busy_s;
  slot_ctrl_e  ctrl_s;
  logic        hazard_s;
  logic        issue_s;
  logic        outbubble_r;
  logic [15:0] hazard_cycles_r;

  // Union of all in-flight definitions
  always_comb begin
    busy_s = {SLOT_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      busy_s = busy_s | slot_q_s[i];
    end
  end

  // Read-after-write check; the issuing instruction's own defs are irrelevant
  always_comb begin
    hazard_s = 1'b0;
    if (!sb.inbubble) begin
      hazard_s = ((sb.use_regs & slot_regs(busy_s)) != {REG_W{1'b0}}) ||
                 (sb.use_cpsr && slot_cpsr(busy_s));
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign issue_s = !sb.inbubble && !hazard_s;

  // Shared slot control; flush wins over stall
  always_comb begin
    ctrl_s = SLOT_LOAD;
    if (sb.flush) begin
      ctrl_s = SLOT_CLEAR;
    end else if (sb.stall) begin
      ctrl_s = SLOT_HOLD;
    end else begin
      ctrl_s = SLOT_LOAD;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    slot_t d_s;
    if (i == 0) begin : g_head
      assign d_s = issue_s ? slot_pack(sb.def_regs, sb.def_cpsr) : {SLOT_W{1'b0}};
    end else begin : g_shift
      assign d_s = slot_q_s[i-1];
    end
    scoreboard_slot u_slot (
      .clk  (clk),
      .rst  (rst),
      .ctrl (ctrl_s),
      .d    (d_s),
      .q    (slot_q_s[i])
    );
  end

  // Bubble handed to the next stage
  always_ff @(posedge clk) begin
    if (rst) begin
      outbubble_r <= 1'b1;
    end else if (sb.flush) begin
      outbubble_r <= 1'b1;
    end else if (sb.stall) begin
      outbubble_r <= outbubble_r;
    end else begin
      outbubble_r <= sb.inbubble | hazard_s;
    end
  end

  // Saturating count of cycles lost to hazards
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_cycles_r <= 16'h0000;
    end else if (hazard_s && !sb.stall && !sb.flush && (hazard_cycles_r != CNT_MAX)) begin
      hazard_cycles_r <= hazard_cycles_r + 16'd1;
    end else begin
      hazard_cycles_r <= hazard_cycles_r;
    end
  end

  assign sb.hazard        = hazard_s;
  assign sb.outbubble     = outbubble_r;
  assign sb.busy_regs     = slot_regs(busy_s);
  assign sb.busy_cpsr     = slot_cpsr(busy_s);
  assign sb.hazard_cycles = hazard_cycles_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard-checked bench: driver pushes expectations from an in-flight list
// model, a negedge monitor pops and compares; a second deep instance saturates.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int DEPTH     = 3;
  localparam int SAT_DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sat_rst;
  logic sat_done = 1'b0;

  issue_scoreboard_if bus ();
  issue_scoreboard_if sat_bus ();

  issue_scoreboard #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  issue_scoreboard #(.DEPTH(SAT_DEPTH)) dut_sat (
    .clk (clk),
    .rst (sat_rst),
    .sb  (sat_bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        haz;
    logic [15:0] busy_regs;
    logic        busy_cpsr;
    logic        ob;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [15:0] regs;
    logic        cpsr;
    int          age;
  } flight_t;

  exp_t    expq[$];
  flight_t inflight[$];
  logic        m_ob  = 1'b1;
  logic [15:0] m_cnt = 16'h0000;

  // inputs applied during the current cycle (consumed at the next edge)
  logic        p_rst = 1'b1, p_stall = 1'b0, p_flush = 1'b0, p_inb = 1'b0;
  logic [15:0] p_ur = 16'h0000, p_dr = 16'h0000;
  logic        p_uc = 1'b0, p_dc = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [16:0] model_busy();
    logic [15:0] br = 16'h0000;
    logic        bc = 1'b0;
    foreach (inflight[i]) begin
      br = br | inflight[i].regs;
      bc = bc | inflight[i].cpsr;
    end
    return {br, bc};
  endfunction

  function automatic logic model_hazard(input logic inb, input logic [15:0] ur, input logic uc);
    logic [16:0] b = model_busy();
    return !inb && (((ur & b[16:1]) != 16'h0000) || (uc && b[0]));
  endfunction

  // Advance the model across one clock edge using the inputs of the ending cycle
  task automatic model_step();
    logic    h;
    flight_t keep[$];
    flight_t f;
    h = model_hazard(p_inb, p_ur, p_uc);
    if (p_rst) begin
      inflight.delete();
      m_ob  = 1'b1;
      m_cnt = 16'h0000;
    end else if (p_flush) begin
      inflight.delete();
      m_ob = 1'b1;
    end else if (!p_stall) begin
      if (h && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      foreach (inflight[i]) begin
        f = inflight[i];
        f.age = f.age + 1;
        if (f.age <= DEPTH) keep.push_back(f);
      end
      inflight = keep;
      if (!p_inb && !h) begin
        f.regs = p_dr;
        f.cpsr = p_dc;
        f.age  = 1;
        inflight.push_back(f);
      end
      m_ob = p_inb | h;
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic f, input logic inb,
                       input logic [15:0] ur, input logic uc,
                       input logic [15:0] dr, input logic dc);
    exp_t        e;
    logic [16:0] b;
    @(posedge clk);
    #1;
    model_step();
    p_rst = r; p_stall = s; p_flush = f; p_inb = inb;
    p_ur = ur; p_uc = uc; p_dr = dr; p_dc = dc;
    rst          = r;
    bus.stall    = s;
    bus.flush    = f;
    bus.inbubble = inb;
    bus.use_regs = ur;
    bus.use_cpsr = uc;
    bus.def_regs = dr;
    bus.def_cpsr = dc;
    b = model_busy();
    e.haz       = model_hazard(inb, ur, uc);
    e.busy_regs = b[16:1];
    e.busy_cpsr = b[0];
    e.ob        = m_ob;
    e.cnt       = m_cnt;
    expq.push_back(e);
  endtask

  task automatic issue(input logic [15:0] ur, input logic uc, input logic [15:0] dr, input logic dc);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, ur, uc, dr, dc);
  endtask

  task automatic bubble();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  // Monitor: compare DUT outputs with the queued expectation mid-cycle
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      check("hazard",        {15'h0000, bus.hazard},    {15'h0000, e.haz});
      check("busy_regs",     bus.busy_regs,             e.busy_regs);
      check("busy_cpsr",     {15'h0000, bus.busy_cpsr}, {15'h0000, e.busy_cpsr});
      check("outbubble",     {15'h0000, bus.outbubble}, {15'h0000, e.ob});
      check("hazard_cycles", bus.hazard_cycles,         e.cnt);
    end
  end

  // Saturation: a self-dependent stream on a deep instance hazards 8 of every 9 cycles
  initial begin
    sat_rst              = 1'b1;
    sat_bus.stall        = 1'b0;
    sat_bus.flush        = 1'b0;
    sat_bus.inbubble     = 1'b0;
    sat_bus.use_regs     = 16'h0002;
    sat_bus.use_cpsr     = 1'b0;
    sat_bus.def_regs     = 16'h0002;
    sat_bus.def_cpsr     = 1'b0;
    repeat (2) @(posedge clk);
    #1 sat_rst = 1'b0;
    repeat (900) @(posedge clk);
    #2 check("sat_partial", sat_bus.hazard_cycles, 16'd800);
    repeat (73100) @(posedge clk);
    #2 check("sat_hold", sat_bus.hazard_cycles, 16'hFFFF);
    sat_done = 1'b1;
  end

  initial begin
    rst          = 1'b1;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.inbubble = 1'b0;
    bus.use_regs = 16'h0000;
    bus.use_cpsr = 1'b0;
    bus.def_regs = 16'h0000;
    bus.def_cpsr = 1'b0;

    // reset, with a reader presented to confirm hazard stays low
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 1'b0);

    // r1 producer then back-to-back reader
    issue(16'h0000, 1'b0, 16'h0002, 1'b0);
    repeat (4) issue(16'h0002, 1'b0, 16'h0000, 1'b0);
    repeat (4) bubble();

    // flags dependency, then a non-reader of flags
    issue(16'h0000, 1'b0, 16'h0000, 1'b1);
    repeat (4) issue(16'h0000, 1'b1, 16'h0000, 1'b0);
    issue(16'h0000, 1'b0, 16'h0000, 1'b1);
    issue(16'h0000, 1'b0, 16'h0000, 1'b0);
    repeat (4) bubble();

    // stall while a reader of r2 waits
    issue(16'h0000, 1'b0, 16'h0004, 1'b0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 16'h0000, 1'b0);
    repeat (4) issue(16'h0004, 1'b0, 16'h0000, 1'b0);

    // flush together with stall discards r3/r4
    issue(16'h0000, 1'b0, 16'h0008, 1'b0);
    issue(16'h0000, 1'b0, 16'h0010, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0018, 1'b0, 16'h0000, 1'b0);
    issue(16'h0018, 1'b0, 16'h0000, 1'b0);
    repeat (4) bubble();

    // reset while a reader is blocked on r5
    issue(16'h0000, 1'b0, 16'h0020, 1'b0);
    issue(16'h0020, 1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 1'b0, 16'h0000, 1'b0);
    issue(16'h0020, 1'b0, 16'h0000, 1'b0);

    // PC bit handled like any other register
    issue(16'h0000, 1'b0, 16'h8000, 1'b0);
    repeat (4) issue(16'h8000, 1'b0, 16'h0000, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic        r, s, f, inb, uc, dc;
      logic [15:0] ur, dr;
      r   = ($urandom_range(0, 63) == 0);
      f   = ($urandom_range(0, 15) == 0);
      s   = ($urandom_range(0, 3) == 0);
      inb = ($urandom_range(0, 4) == 0);
      ur  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      dr  = 16'($urandom) & 16'($urandom);
      uc  = ($urandom_range(0, 3) == 0);
      dc  = ($urandom_range(0, 2) == 0);
      cycle(r, s, f, inb, ur, uc, dr, dc);
    end
    repeat (6) bubble();

    wait (sat_done);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
